synchronous_fifo: RTL and testbench
===================================

// Module: synchronous_fifo
// PURPOSE
//   Single-clock first-in/first-out buffer, 8 entries x 3 bits by default.
//   Decouples a producer and a consumer that share one clock domain.
//   Write and read enables are gated internally by full/empty.
//   Status flags report occupancy and illegal accesses.
// PARAMETERS
//   DATA_WIDTH  3  width of each stored word
//   DEPTH       8  number of entries; must be a power of two, >= 2
//   ADDR_WIDTH  $clog2(DEPTH) (3)  derived local parameter; not overridable
// PORTS
//   clk         in   1             single clock; all state updates on the rising edge
//   reset_i     in   1             asynchronous, active-high reset
//   wr_en_i     in   1             write request
//   data_i      in   DATA_WIDTH    write data, sampled on the clk edge with wr_en_i
//   rd_en_i     in   1             read request
//   data_o      out  DATA_WIDTH    registered read data
//   full_o      out  1             FIFO holds DEPTH entries
//   empty_o     out  1             FIFO holds 0 entries
//   count_o     out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//   overflow_o  out  1             one-cycle pulse: write requested while full
//   underflow_o out  1             one-cycle pulse: read requested while empty
// BEHAVIOUR
//   - Reset (asserted at any time, including mid-operation) forces immediately:
//     - wr_ptr=0, rd_ptr=0, data_o=0, count_o=0
//     - empty_o=1, full_o=0, overflow_o=0, underflow_o=0
//     - Memory contents are not cleared; stored data is discarded logically.
//   - Pointers are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits index memory.
//     The MSB is a wrap bit, so pointers wrap naturally modulo 2*DEPTH.
//   - Flags are combinational from the registered pointers (no extra latency):
//     - empty_o = (wr_ptr == rd_ptr)
//     - full_o  = low bits equal AND MSBs differ
//     - count_o = wr_ptr - rd_ptr (modulo 2^(ADDR_WIDTH+1))
//   - Write: if wr_en_i && !full_o at the edge, mem[wr_ptr] <= data_i and wr_ptr++.
//     - While full, writes are dropped and overflow_o=1 for that cycle.
//   - Read: if rd_en_i && !empty_o at the edge, data_o <= mem[rd_ptr] and rd_ptr++.
//     - Read latency is one cycle: data is valid after the edge that accepts the read.
//     - While empty, data_o holds its last value and underflow_o=1 for that cycle.
//   - data_o holds its value whenever no read is accepted.
//   - Simultaneous write and read:
//     - Each is qualified independently against the flags as they stood before the edge.
//     - When neither full nor empty, both occur and count_o is unchanged.
//     - When full, only the read occurs; when empty, only the write occurs.
//     - No write-to-read bypass.
//   - Behaviour when DEPTH is not a power of two is unsupported; an elaboration
//     check flags it.
// STRUCTURE
//   - Package fifo_pkg: default DATA_WIDTH/DEPTH constants and a ptr width helper.
//   - Sub-module fifo_mem: DEPTH x DATA_WIDTH dual-port RAM.
//     - Synchronous write port and synchronous registered read port, no reset on the array.
//     - synchronous_fifo holds the pointers, flags, counters and error pulses.
// TESTING (clk period 10 ns)
//   1. Pulse reset_i 1 cycle -> empty_o=1, full_o=0, count_o=0, data_o=0 (async, before next edge).
//   2. Write 0..7 on 8 consecutive edges -> count_o steps 1..8; full_o=1 after 8th edge; empty_o=0.
//   3. From full, read 8 cycles -> data_o=0,1,..,7, one per edge.
//      -> empty_o=1 after the 8th read; the 9th read gives underflow_o=1 and data_o stays 7.
//   4. Repeat write 0..7 / read 8 (pointer wrap) -> identical data_o sequence.
//      -> 9th write attempt gives overflow_o=1 with memory unchanged.
//   5. With count=4, assert wr_en_i and rd_en_i together for 4 cycles -> count_o stays 4; order preserved.
//   6. Assert reset_i mid-burst at count=5 -> immediate empty_o=1, count_o=0.
//      -> Next writes start at entry 0 and read back correctly.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and pointer-width helper for the synchronous FIFO
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 3;
  localparam int DEFAULT_DEPTH      = 8;

  // One extra wrap bit beyond the memory index distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH dual-port RAM with registered read port
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The array itself is never reset; stale contents are discarded by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/synchronous_fifo.sv
// rtl/synchronous_fifo.sv - single-clock FIFO with occupancy flags and overflow/underflow pulses
module synchronous_fifo
  import fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int PTR_WIDTH = ptr_width(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("synchronous_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 wr_accept;
  logic                 rd_accept;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign count_o = wr_ptr - rd_ptr;

  // Both requests are qualified against the flags as they stand before the edge.
  assign wr_accept = wr_en_i && !full_o;
  assign rd_accept = rd_en_i && !empty_o;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      overflow_o  <= wr_en_i && full_o;
      underflow_o <= rd_en_i && empty_o;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk    (clk),
    .rst    (reset_i),
    .wr_en  (wr_accept),
    .wr_addr(wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data(data_i),
    .rd_en  (rd_accept),
    .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data(data_o)
  );

endmodule

// File: tb/tb_synchronous_fifo.sv
// tb/tb_synchronous_fifo.sv - randomized and directed self-checking bench for synchronous_fifo
module tb_synchronous_fifo;

  localparam int DW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          wr_en_i;
  logic [DW-1:0] data_i;
  logic          rd_en_i;
  logic [DW-1:0] data_o;
  logic          full_o;
  logic          empty_o;
  logic [3:0]    count_o;
  logic          overflow_o;
  logic          underflow_o;

  synchronous_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .wr_en_i    (wr_en_i),
    .data_i     (data_i),
    .rd_en_i    (rd_en_i),
    .data_o     (data_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: a plain queue of stored words plus the last value read out.
  int q[$];
  int exp_data;
  int exp_ovf;
  int exp_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"},      32'(data_o),      32'(exp_data));
    check({tag, ".count"},     32'(count_o),     32'(q.size()));
    check({tag, ".full"},      32'(full_o),      32'(q.size() == DEPTH));
    check({tag, ".empty"},     32'(empty_o),     32'(q.size() == 0));
    check({tag, ".overflow"},  32'(overflow_o),  32'(exp_ovf));
    check({tag, ".underflow"}, 32'(underflow_o), 32'(exp_unf));
  endtask

  task automatic model_clear();
    q.delete();
    exp_data = 0;
    exp_ovf  = 0;
    exp_unf  = 0;
  endtask

  task automatic step(input string tag, input bit wr, input int d, input bit rd);
    bit was_full;
    bit was_empty;
    logic [DW-1:0] dv;
    dv      = d[DW-1:0];
    wr_en_i = wr;
    data_i  = dv;
    rd_en_i = rd;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    exp_ovf   = (wr && was_full) ? 1 : 0;
    exp_unf   = (rd && was_empty) ? 1 : 0;
    if (rd && !was_empty) exp_data = q.pop_front();
    if (wr && !was_full) q.push_back(int'(dv));
    @(negedge clk);
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    check_all(tag);
  endtask

  // Reset lands mid-cycle so its effect is checked before any clock edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 reset_i = 1'b1;
    #1 model_clear();
    check_all({tag, ".async"});
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    check_all({tag, ".held"});
  endtask

  initial begin
    reset_i = 1'b1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    data_i  = '0;
    model_clear();
    #3 check_all("por");
    @(negedge clk);
    reset_i = 1'b0;

    pulse_reset("rst1");

    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, i, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step("drain", 1'b0, 0, 1'b1);

    for (int i = 0; i < DEPTH; i++) step("wrap_fill", 1'b1, i, 1'b0);
    step("ovf", 1'b1, 5, 1'b0);
    step("ovf_clear", 1'b0, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("wrap_drain", 1'b0, 0, 1'b1);

    for (int i = 0; i < 4; i++) step("half_fill", 1'b1, $urandom_range(0, 7), 1'b0);
    for (int i = 0; i < 4; i++) step("simul", 1'b1, $urandom_range(0, 7), 1'b1);
    for (int i = 0; i < 4; i++) step("simul_drain", 1'b0, 0, 1'b1);
    step("simul_empty", 1'b1, 6, 1'b1);
    step("simul_empty_rd", 1'b0, 0, 1'b1);

    for (int i = 0; i < DEPTH; i++) step("full_fill", 1'b1, 7 - i, 1'b0);
    step("simul_full", 1'b1, 2, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("full_drain", 1'b0, 0, 1'b1);

    for (int i = 0; i < 5; i++) step("burst", 1'b1, i + 2, 1'b0);
    pulse_reset("rst_mid");
    for (int i = 0; i < 4; i++) step("post_rst_wr", 1'b1, i, 1'b0);
    for (int i = 0; i < 4; i++) step("post_rst_rd", 1'b0, 0, 1'b1);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset("rand_rst");
      end else begin
        step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
